// File: rtl/rv6_bus_pkg.sv
// Shared bus constants for the data-side BIU: FSM encoding, beat counts and m_addr field positions.
package rv6_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        RD_DONE  = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    localparam int BEATS      = 16;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int BEAT_LSB   = 3;                       // byte offset inside a 64-bit beat
    localparam int LINE_LSB   = BEAT_LSB + BEAT_IDX_W;   // first line-address bit (7)

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

endpackage

// File: rtl/dmem_biu_wbuf.sv
// One-line write-through buffer: rising-edge capture of c_wr, valid flag, line storage and
// per-beat write data selection.
module dmem_biu_wbuf
    import rv6_bus_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 1024,
    parameter int BEAT_W = 64
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       c_wr,
    input  logic [ADDR_W-1:LINE_LSB]   c_line,
    input  logic [LINE_W-1:0]          c_data_in,
    input  logic                       drain,
    input  logic [BEAT_IDX_W-1:0]      beat,
    output logic                       valid,
    output logic [ADDR_W-1:LINE_LSB]   line_addr,
    output logic [BEAT_W-1:0]          wdata
);

    logic              c_wr_q;
    logic              capture;
    logic [LINE_W-1:0] line_q;

    // drain marks the last cycle of the write burst, so a new line may replace the old one then
    assign capture = c_wr && !c_wr_q && (!valid || drain);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            c_wr_q    <= 1'b0;
            valid     <= 1'b0;
            line_addr <= '0;
            line_q    <= '0;
        end else begin
            c_wr_q <= c_wr;
            if (capture) begin
                valid     <= 1'b1;
                line_addr <= c_line;
                line_q    <= c_data_in;
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end

    assign wdata = line_q[BEAT_W*int'(beat) +: BEAT_W];

endmodule

// File: rtl/dmem_biu.sv
// L1 data-cache bus interface unit: line fills and write-throughs as 16 single-beat req/ack transfers.
// Optional burst watchdog enabled with `define DMEM_BIU_TIMEOUT_EN.
module dmem_biu
    import rv6_bus_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int LINE_W      = 1024,
    parameter int BEAT_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic              c_rd,
    output logic              c_dv,
    output logic [LINE_W-1:0] c_data_out,
    input  logic              c_wr,
    input  logic [LINE_W-1:0] c_data_in,
    output logic              c_wfull,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [BEAT_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [BEAT_W-1:0] m_rdata,
    output logic              bus_err
);

    // Memory handshake: m_req/m_we/m_addr/m_wdata are held unchanged until m_ack is sampled high;
    // a beat transfers on the clock edge where m_req && m_ack, with m_rdata valid in that same cycle.

    state_t                    state_q, state_d;
    logic [BEAT_IDX_W-1:0]     beat_q;
    logic [ADDR_W-1:LINE_LSB]  rd_line_q;
    logic [ADDR_W-1:LINE_LSB]  c_line;
    logic                      wb_valid;
    logic [ADDR_W-1:LINE_LSB]  wb_line;
    logic [BEAT_W-1:0]         wb_wdata;
    logic                      in_burst;
    logic                      last_ack;
    logic                      timeout;
    logic                      wr_drain;
    logic                      unused_addr_lsb;

    assign c_line          = c_addr[ADDR_W-1:LINE_LSB];
    assign unused_addr_lsb = ^c_addr[LINE_LSB-1:0];
    assign in_burst        = (state_q == RD_BURST) || (state_q == WR_BURST);
    assign last_ack        = in_burst && m_ack && (beat_q == LAST_BEAT);
    assign wr_drain        = (state_q == WR_BURST) && (last_ack || timeout);
    assign c_wfull         = wb_valid;

    dmem_biu_wbuf #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_wbuf (
        .clk       (clk),
        .clr_n     (clr_n),
        .c_wr      (c_wr),
        .c_line    (c_line),
        .c_data_in (c_data_in),
        .drain     (wr_drain),
        .beat      (beat_q),
        .valid     (wb_valid),
        .line_addr (wb_line),
        .wdata     (wb_wdata)
    );

`ifdef DMEM_BIU_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            bus_err_q;

    // counts consecutive un-acked request cycles of the current beat
    assign timeout = in_burst && !m_ack && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
    assign bus_err = bus_err_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wd_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (!in_burst || m_ack) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // a pending write to the line being filled must reach memory first
                if (c_rd && wb_valid && (c_line == wb_line)) begin
                    state_d = WR_BURST;
                end else if (c_rd) begin
                    state_d = RD_BURST;
                end else if (wb_valid) begin
                    state_d = WR_BURST;
                end
            end
            RD_BURST: begin
                if (timeout) begin
                    state_d = IDLE;
                end else if (last_ack) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE:  state_d = IDLE;
            WR_BURST: begin
                if (timeout || last_ack) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            beat_q     <= '0;
            rd_line_q  <= '0;
            c_data_out <= '0;
        end else begin
            if ((state_q == IDLE) && (state_d == RD_BURST)) begin
                rd_line_q <= c_line;
            end
            // beat wraps to 0 after the 16th ack, ready for the next burst
            if (timeout) begin
                beat_q <= '0;
            end else if (in_burst && m_ack) begin
                beat_q <= beat_q + 1'b1;
            end
            if ((state_q == RD_BURST) && m_ack) begin
                c_data_out[BEAT_W*int'(beat_q) +: BEAT_W] <= m_rdata;
            end
        end
    end

    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        c_dv    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        unique case (state_q)
            RD_BURST: begin
                m_req  = 1'b1;
                m_addr = {rd_line_q, beat_q, {BEAT_LSB{1'b0}}};
            end
            WR_BURST: begin
                m_req   = 1'b1;
                m_we    = 1'b1;
                m_addr  = {wb_line, beat_q, {BEAT_LSB{1'b0}}};
                m_wdata = wb_wdata;
            end
            RD_DONE:  c_dv = 1'b1;
            default:  ;
        endcase
    end

endmodule
